// File: rtl/tagged_req_pkg.sv
// Shared request types for the tagged request arbiter: beat kind, beat payload
// and the arbiter FSM state.
package tagged_req_pkg;

  localparam int PKT_ADDR_W = 16;
  localparam int PKT_DATA_W = 32;
  localparam int PKT_LEN_W  = 4;

  typedef enum logic [1:0] {
    REQ_NOP   = 2'd0,
    REQ_READ  = 2'd1,
    REQ_WRITE = 2'd2
  } req_kind_e;

  typedef struct packed {
    req_kind_e               kind;
    logic [PKT_LEN_W-1:0]    len;
    logic [PKT_ADDR_W-1:0]   addr;
    logic [PKT_DATA_W-1:0]   data;
  } req_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/tagged_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping past NUM_REQ-1 back to 0.
module tagged_req_arbiter_rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest offset down so the closest hit to ptr wins last.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (req[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        idx       = cand;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tagged_req_arbiter.sv
// Round-robin arbiter sharing one registered downstream slot between NUM_REQ
// requesters; multi-beat WRITE bursts hold the grant until their last beat.
module tagged_req_arbiter
  import tagged_req_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int ADDR_W  = PKT_ADDR_W,
  parameter  int DATA_W  = PKT_DATA_W,
  parameter  int LEN_W   = PKT_LEN_W,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  req_t [NUM_REQ-1:0]   req_pkt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output req_t                 out_pkt,
  output logic [IDX_W-1:0]     out_src,
  output logic                 busy
);

  localparam int SLOT_W = $bits(req_kind_e) + LEN_W + ADDR_W + DATA_W;

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               slot_vld_q, slot_vld_d;
  logic [SLOT_W-1:0]  slot_pkt_q, slot_pkt_d;
  logic [IDX_W-1:0]   slot_src_q, slot_src_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               slot_free;
  logic               accept;
  logic [IDX_W-1:0]   win_idx;
  req_t               win_pkt;
  req_t               fwd_pkt;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  tagged_req_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Grant: burst owner is pinned; otherwise the picker decides. Nothing is
  // offered while the slot is full and stalled.
  always_comb begin
    slot_free = !slot_vld_q || out_ready;
    win_idx   = (state_q == ST_BURST) ? owner_q : pick_idx;
    win_pkt   = req_pkt[win_idx];
    req_ready = '0;
    accept    = 1'b0;
    if (!rst && slot_free) begin
      if (state_q == ST_BURST) begin
        req_ready[owner_q] = 1'b1;
        accept             = req_valid[owner_q];
      end else begin
        req_ready = pick_gnt;
        accept    = pick_any;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    slot_vld_d = slot_free ? 1'b0 : slot_vld_q;
    slot_pkt_d = slot_pkt_q;
    slot_src_d = slot_src_q;
    fwd_pkt    = win_pkt;
    if (accept) begin
      if (state_q == ST_BURST) begin
        fwd_pkt.kind = REQ_WRITE;
        slot_vld_d   = 1'b1;
        slot_pkt_d   = fwd_pkt;
        slot_src_d   = win_idx;
        beat_cnt_d   = beat_cnt_q - 1'b1;
        if (beat_cnt_q == LEN_W'(1)) begin
          state_d  = ST_IDLE;
          rr_ptr_d = wrap_inc(owner_q);
        end
      end else if (win_pkt.kind == REQ_NOP) begin
        rr_ptr_d = wrap_inc(win_idx);
      end else begin
        slot_vld_d = 1'b1;
        slot_pkt_d = fwd_pkt;
        slot_src_d = win_idx;
        if (win_pkt.kind == REQ_WRITE && win_pkt.len != '0) begin
          state_d    = ST_BURST;
          owner_d    = win_idx;
          beat_cnt_d = win_pkt.len;
        end else begin
          rr_ptr_d = wrap_inc(win_idx);
        end
      end
    end
  end

  // Output slot / FSM register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
      slot_vld_q <= 1'b0;
      slot_pkt_q <= '0;
      slot_src_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
      slot_vld_q <= slot_vld_d;
      slot_pkt_q <= slot_pkt_d;
      slot_src_q <= slot_src_d;
    end
  end

  assign out_valid = slot_vld_q;
  assign out_pkt   = req_t'(slot_pkt_q);
  assign out_src   = slot_src_q;
  assign busy      = (state_q == ST_BURST);

endmodule

// File: tb/tb_tagged_req_arbiter.sv
// Bench for tagged_req_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_tagged_req_arbiter;
  import tagged_req_pkg::*;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  req_t [N-1:0]  req_pkt;
  logic          out_valid;
  logic          out_ready;
  req_t          out_pkt;
  logic [1:0]    out_src;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int   m_rr, m_owner, m_rem, m_ssrc;
  bit   m_burst, m_sv;
  req_t m_spkt;

  always #5 clk = ~clk;

  tagged_req_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_pkt   (req_pkt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pkt   (out_pkt),
    .out_src   (out_src),
    .busy      (busy)
  );

  function automatic req_t mk(req_kind_e k, int len, int data);
    req_t p;
    p.kind = k;
    p.len  = PKT_LEN_W'(len);
    p.addr = PKT_ADDR_W'(data * 3);
    p.data = PKT_DATA_W'(data);
    return p;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    r = '0;
    if (rst) return r;
    if (m_sv && !out_ready) return r;
    if (m_burst) begin
      r[m_owner] = 1'b1;
      return r;
    end
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_rr + k) % N]) begin
        r[(m_rr + k) % N] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  // Advance the model by one clock using the inputs currently driven, then clock.
  task automatic tick();
    logic [N-1:0] r;
    int           w;
    req_t         p;
    r = exp_ready();
    w = -1;
    for (int i = 0; i < N; i++) if (r[i] && req_valid[i]) w = i;
    if (rst) begin
      m_rr = 0; m_owner = 0; m_rem = 0; m_burst = 0; m_sv = 0; m_spkt = '0; m_ssrc = 0;
    end else begin
      if (!m_sv || out_ready) m_sv = 0;
      if (w >= 0) begin
        p = req_pkt[w];
        if (m_burst) begin
          p.kind = REQ_WRITE;
          m_sv = 1; m_spkt = p; m_ssrc = w;
          m_rem = m_rem - 1;
          if (m_rem == 0) begin
            m_burst = 0;
            m_rr    = (w + 1) % N;
          end
        end else if (p.kind == REQ_NOP) begin
          m_rr = (w + 1) % N;
        end else begin
          m_sv = 1; m_spkt = p; m_ssrc = w;
          if (p.kind == REQ_WRITE && p.len != 0) begin
            m_burst = 1; m_owner = w; m_rem = int'(p.len);
          end else begin
            m_rr = (w + 1) % N;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic all_read(int base);
    for (int i = 0; i < N; i++) req_pkt[i] = mk(REQ_READ, 0, base + i);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '1; out_ready = 1'b1;
    all_read(1);
    #1;
    n_checks++;
    if (req_ready !== '0) $display("FAIL reset_ready_in_rst: got %b want 0000", req_ready); else n_pass++;
    tick();
    tick();
    n_checks++;
    if ({out_valid, busy, out_src} !== 4'b0000)
      $display("FAIL reset_ctrl: got valid=%b busy=%b src=%0d want 0/0/0", out_valid, busy, out_src);
    else n_pass++;
    n_checks++;
    if (out_pkt !== '0) $display("FAIL reset_pkt: got %h want 0", out_pkt); else n_pass++;
    rst = 1'b0; req_valid = '0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] e;
    do_reset();
    all_read(10);
    req_valid = '1; out_ready = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL rr_first_idle: got %b want 0", out_valid); else n_pass++;
    for (int c = 0; c < 5; c++) begin
      e = '0; e[c % N] = 1'b1;
      #1;
      n_checks++;
      if (req_ready !== e) $display("FAIL rr_ready c%0d: got %b want %b", c, req_ready, e); else n_pass++;
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_src !== 2'(c % N) || out_pkt.data !== 32'(10 + c % N))
        $display("FAIL rr_out c%0d: got v=%b src=%0d data=%0d want 1/%0d/%0d",
                 c, out_valid, out_src, out_pkt.data, c % N, 10 + c % N);
      else n_pass++;
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_write_burst();
    logic [N-1:0] e;
    do_reset();
    out_ready = 1'b1;
    req_pkt[0] = mk(REQ_READ, 0, 7);
    req_valid  = 4'b0010;
    for (int t = 0; t < 5; t++) begin
      req_pkt[1] = (t == 0) ? mk(REQ_WRITE, 3, 100) : mk(REQ_READ, 0, 100 + t);
      e = (t < 4) ? 4'b0010 : 4'b0001;
      #1;
      n_checks++;
      if (req_ready !== e) $display("FAIL burst_ready t%0d: got %b want %b", t, req_ready, e); else n_pass++;
      tick();
      req_valid = 4'b0011;
      n_checks++;
      if (out_src !== ((t < 4) ? 2'd1 : 2'd0) || out_pkt.kind !== ((t < 4) ? REQ_WRITE : REQ_READ))
        $display("FAIL burst_src t%0d: got src=%0d kind=%0d", t, out_src, out_pkt.kind);
      else n_pass++;
      n_checks++;
      if (out_pkt.data !== ((t < 4) ? 32'(100 + t) : 32'd7))
        $display("FAIL burst_data t%0d: got %0d want %0d", t, out_pkt.data, (t < 4) ? 100 + t : 7);
      else n_pass++;
      n_checks++;
      if (busy !== (t < 3)) $display("FAIL burst_busy t%0d: got %b want %b", t, busy, t < 3); else n_pass++;
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_backpressure();
    req_t saved;
    do_reset();
    all_read(20);
    req_valid = '1; out_ready = 1'b1;
    #1;
    tick();
    saved = out_pkt;
    n_checks++;
    if (saved.data !== 32'd20) $display("FAIL bp_first: got %0d want 20", saved.data); else n_pass++;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if (req_ready !== '0) $display("FAIL bp_ready c%0d: got %b want 0000", c, req_ready); else n_pass++;
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_src !== 2'd0 || out_pkt !== saved)
        $display("FAIL bp_hold c%0d: got v=%b src=%0d pkt=%h want 1/0/%h", c, out_valid, out_src, out_pkt, saved);
      else n_pass++;
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) $display("FAIL bp_release_ready: got %b want 0010", req_ready); else n_pass++;
    tick();
    n_checks++;
    if (out_src !== 2'd1 || out_pkt.data !== 32'd21)
      $display("FAIL bp_next: got src=%0d data=%0d want 1/21", out_src, out_pkt.data);
    else n_pass++;
    req_valid = '0;
    tick();
  endtask

  task automatic test_nop();
    do_reset();
    out_ready  = 1'b1;
    req_pkt[2] = mk(REQ_NOP, 0, 55);
    req_valid  = 4'b0100;
    #1;
    n_checks++;
    if (req_ready !== 4'b0100) $display("FAIL nop_ready: got %b want 0100", req_ready); else n_pass++;
    tick();
    req_valid = '0;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL nop_dropped: got %b want 0", out_valid); else n_pass++;
    tick();
    all_read(30);
    req_valid = '1;
    #1;
    n_checks++;
    if (req_ready !== 4'b1000) $display("FAIL nop_rr_ptr: got %b want 1000", req_ready); else n_pass++;
    tick();
    n_checks++;
    if (out_src !== 2'd3 || out_valid !== 1'b1) $display("FAIL nop_next: got src=%0d v=%b want 3/1", out_src, out_valid); else n_pass++;
    req_valid = '0;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    out_ready  = 1'b1;
    req_pkt[2] = mk(REQ_WRITE, 5, 60);
    req_valid  = 4'b0100;
    #1;
    tick();
    n_checks++;
    if (busy !== 1'b1 || out_valid !== 1'b1) $display("FAIL rstb_start: got busy=%b v=%b want 1/1", busy, out_valid); else n_pass++;
    rst = 1'b1;
    #1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rstb_clear: got v=%b busy=%b want 0/0", out_valid, busy); else n_pass++;
    rst = 1'b0;
    all_read(70);
    req_valid = '1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) $display("FAIL rstb_ready: got %b want 0001", req_ready); else n_pass++;
    tick();
    n_checks++;
    if (out_src !== 2'd0 || out_pkt.data !== 32'd70) $display("FAIL rstb_first: got src=%0d data=%0d want 0/70", out_src, out_pkt.data); else n_pass++;
    req_valid = '0;
    tick();
  endtask

  task automatic test_owner_bubbles();
    do_reset();
    out_ready  = 1'b1;
    req_pkt[1] = mk(REQ_WRITE, 3, 80);
    req_pkt[3] = mk(REQ_READ, 0, 90);
    req_valid  = 4'b0010;
    #1;
    tick();
    req_valid = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (req_ready !== 4'b0010) $display("FAIL bub_ready c%0d: got %b want 0010", c, req_ready); else n_pass++;
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b1) $display("FAIL bub_out c%0d: got v=%b busy=%b want 0/1", c, out_valid, busy); else n_pass++;
    end
    req_valid = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      req_pkt[1] = mk(REQ_WRITE, 3, 81 + c);
      #1;
      n_checks++;
      if (req_ready !== 4'b0010) $display("FAIL bub_resume c%0d: got %b want 0010", c, req_ready); else n_pass++;
      tick();
      n_checks++;
      if (out_src !== 2'd1 || out_pkt.data !== 32'(81 + c))
        $display("FAIL bub_beat c%0d: got src=%0d data=%0d want 1/%0d", c, out_src, out_pkt.data, 81 + c);
      else n_pass++;
    end
    #1;
    n_checks++;
    if (req_ready !== 4'b1000) $display("FAIL bub_after_ready: got %b want 1000", req_ready); else n_pass++;
    tick();
    n_checks++;
    if (out_src !== 2'd3 || out_pkt.data !== 32'd90) $display("FAIL bub_after: got src=%0d data=%0d want 3/90", out_src, out_pkt.data); else n_pass++;
    req_valid = '0;
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] e;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom_range(0, 2) != 0);
        req_pkt[i]   = mk(req_kind_e'($urandom_range(0, 2)), int'($urandom_range(0, 3)), int'($urandom));
      end
      #1;
      e = exp_ready();
      n_checks++;
      if (req_ready !== e) $display("FAIL rand_ready c%0d: got %b want %b", c, req_ready, e); else n_pass++;
      tick();
      n_checks++;
      if (out_valid !== m_sv || busy !== m_burst)
        $display("FAIL rand_ctrl c%0d: got v=%b busy=%b want %b/%b", c, out_valid, busy, m_sv, m_burst);
      else n_pass++;
      if (m_sv) begin
        n_checks++;
        if (out_src !== 2'(m_ssrc) || out_pkt !== m_spkt)
          $display("FAIL rand_pkt c%0d: got src=%0d pkt=%h want %0d/%h", c, out_src, out_pkt, m_ssrc, m_spkt);
        else n_pass++;
      end
    end
    rst = 1'b0;
    req_valid = '0;
    tick();
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; out_ready = 1'b1; req_pkt = '0;
    m_rr = 0; m_owner = 0; m_rem = 0; m_burst = 0; m_sv = 0; m_spkt = '0; m_ssrc = 0;
    test_reset();
    test_round_robin();
    test_write_burst();
    test_backpressure();
    test_nop();
    test_reset_mid_burst();
    test_owner_bubbles();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
